ntt_stream_loader: RTL

//  Upstream/downstream BRAM master for the NTT wrapper's BRAM port B. Accepts a frame of N 64-bit

---
 rtl/ntt_pkg.sv | 26 ++
 rtl/ntt_rd_fifo.sv | 54 +++++
 rtl/ntt_stream_loader.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/ntt_pkg.sv
// Shared state encoding, default widths and the bit-reversal helper for the NTT stream loader.
// Build option: NTT_LOADER_BITREV_EN selects bit-reversed write ordering in ntt_stream_loader.
package ntt_pkg;

  localparam int unsigned NTT_DATA_W = 64;
  localparam int unsigned NTT_ADDR_W = 13;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  // Reverses the low log_n bits of idx; bits above log_n come back as zero.
  function automatic logic [15:0] bitrev(input logic [15:0] idx, input int unsigned log_n);
    logic [15:0] r;
    r = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i < log_n) r[4'(i)] = idx[4'(log_n - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/ntt_rd_fifo.sv
// Read-return FIFO for the loader's drain path; first-word fall-through so a word
// arriving into an empty FIFO is presented on dout in the same cycle.
module ntt_rd_fifo #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              empty;
  logic              store;
  logic              take;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty = (count == '0);
  assign valid = !empty || push;
  assign dout  = empty ? din : mem[rd_ptr];
  assign take  = pop && !empty;
  // A word that arrives into an empty FIFO and is consumed at once never lands in storage.
  assign store = push && !(empty && pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) wr_ptr <= next_ptr(wr_ptr);
      if (take)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(store) - CNT_W'(take);
    end
  end

  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ntt_stream_loader.sv
// Stream <-> BRAM port-B master for the NTT wrapper: loads a frame, starts the kernel, drains results.
// Build option: NTT_LOADER_BITREV_EN writes the frame in bit-reversed word order.
module ntt_stream_loader
  import ntt_pkg::*;
#(
  parameter int unsigned DATA_W    = NTT_DATA_W,
  parameter int unsigned ADDR_W    = NTT_ADDR_W,
  parameter int unsigned LOG_N     = 10,
  parameter int unsigned BASE_WORD = 0,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              ntt_start,
  input  logic              ntt_done,
  output logic [ADDR_W-1:0] BRAM_addr,
  output logic              BRAM_clk,
  output logic [DATA_W-1:0] BRAM_din,
  input  logic [DATA_W-1:0] BRAM_dout,
  output logic              BRAM_en,
  output logic              BRAM_we,
  output logic              BRAM_rst,
  output logic              busy,
  output logic              err_len
);

  localparam int unsigned CW    = LOG_N + 1;
  localparam int unsigned DEPTH = RD_LAT + 2;
  localparam int unsigned FCW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] N_WORDS = CW'(1 << LOG_N);
  localparam logic [CW-1:0] N_LAST  = CW'((1 << LOG_N) - 1);

  state_t              state;
  logic [CW-1:0]       wi;
  logic [CW-1:0]       ri;
  logic [CW-1:0]       ro;
  logic                err_q;
  logic [RD_LAT-1:0]   rd_pipe;

  logic                accept;
  logic                rd_issue;
  logic                credit_ok;
  logic                pop;
  logic                push;
  logic [LOG_N-1:0]    wr_idx;
  logic [LOG_N-1:0]    idx_sel;
  logic [ADDR_W-1:0]   word_addr;
  logic [FCW-1:0]      fifo_count;
  logic [DATA_W-1:0]   fifo_dout;
  logic                fifo_valid;
  int unsigned         in_flight;

`ifdef NTT_LOADER_BITREV_EN
  assign wr_idx = LOG_N'(bitrev(16'(wi[LOG_N-1:0]), LOG_N));
`else
  assign wr_idx = wi[LOG_N-1:0];
`endif

  assign accept    = (state == LOAD) && s_valid;
  assign in_flight = $countones(rd_pipe);
  // Reads are throttled so every outstanding return always has a FIFO slot, whatever m_ready does.
  assign credit_ok = (32'(fifo_count) + in_flight) < DEPTH;
  assign rd_issue  = (state == DRAIN) && (ri != N_WORDS) && credit_ok;
  assign push      = rd_pipe[RD_LAT-1];
  assign pop       = fifo_valid && m_ready;

  assign s_ready   = (state == LOAD);
  assign ntt_start = (state == START);
  assign busy      = (state != IDLE);
  assign err_len   = err_q;

  assign m_valid   = fifo_valid;
  assign m_data    = fifo_valid ? fifo_dout : '0;
  assign m_last    = fifo_valid && (ro == N_LAST);

  assign idx_sel   = accept ? wr_idx : ri[LOG_N-1:0];
  assign word_addr = ADDR_W'(BASE_WORD) + ADDR_W'(idx_sel);
  assign BRAM_en   = accept || rd_issue;
  assign BRAM_we   = accept;
  assign BRAM_din  = accept ? s_data : '0;
  assign BRAM_addr = BRAM_en ? (word_addr << 3) : '0;
  assign BRAM_clk  = clk;
  assign BRAM_rst  = 1'b0;

  ntt_rd_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (FCW)
  ) u_rd_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .din   (BRAM_dout),
    .pop   (pop),
    .dout  (fifo_dout),
    .valid (fifo_valid),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe <= (rd_pipe << 1) | RD_LAT'(rd_issue);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      wi    <= '0;
      ri    <= '0;
      ro    <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= LOAD;
        LOAD: begin
          if (accept) begin
            if (wi + CW'(1) == N_WORDS) begin
              state <= START;
              wi    <= '0;
              err_q <= !s_last;
            end else if (s_last) begin
              state <= IDLE;
              wi    <= '0;
              err_q <= 1'b1;
            end else begin
              wi <= wi + CW'(1);
              if (wi == '0) err_q <= 1'b0;
            end
          end
        end
        START: state <= WAIT;
        WAIT: begin
          if (ntt_done) state <= DRAIN;
        end
        DRAIN: begin
          if (rd_issue) ri <= ri + CW'(1);
          if (pop) begin
            if (ro == N_LAST) begin
              state <= IDLE;
              ri    <= '0;
              ro    <= '0;
            end else begin
              ro <= ro + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
